jscan_tier_seq: RTL and testbench

Parametrised test sequencer with per-tier signature compaction for the monolithic 3D-JSCAN fabric. One block walks N_TIERS tiers in order and runs a programmable number of patterns per tier in serial (SAS), random-access (RAS) or hybrid mode. Scan response is compacted into one MISR per tier and checked against supplied golden signatures, giving a per-tier fault vector and a start/done handshake. It replaces the fixed-mode, fixed-size global test controller with runtime mode selection and a pass/fail verdict.

---
 rtl/jscan_tier_seq.sv | 201 ++++++++++++++++++++
 tb/tb_jscan_tier_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jscan_tier_seq.sv
// Tier-walking scan test sequencer for the 3D-JSCAN fabric: runs SAS/RAS/hybrid
// patterns tier by tier, compacts each tier's response into a MISR and checks it.
module jscan_tier_seq #(
  parameter int N_TIERS = 3,
  parameter int CHAIN_LEN = 8,
  parameter int ADDR_W = 4,
  parameter int MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY = 16'h100B
) (
  input  logic                        scan_clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 pattern_cnt,
  input  logic                        test_enable,
  input  logic                        scan_in,
  input  logic [N_TIERS*MISR_W-1:0]   golden_sig,
  output logic [N_TIERS-1:0]          tier_sel,
  output logic [ADDR_W-1:0]           col_addr,
  output logic                        shift_en,
  output logic                        capture_en,
  output logic [N_TIERS*MISR_W-1:0]   misr_sig,
  output logic [N_TIERS-1:0]          fault_vec,
  output logic                        fault_flag,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  output logic [2:0]                  state_dbg
);

  // Handshake: start is accepted only in IDLE with a legal mode; busy is high from
  // the cycle after acceptance through COMPARE; done pulses for one cycle after that.

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_ACCESS  = 3'd3;
  localparam logic [2:0] ST_COMPARE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [1:0] MODE_SAS = 2'b00;
  localparam logic [1:0] MODE_RAS = 2'b01;
  localparam logic [1:0] MODE_HYB = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int TIER_W = (N_TIERS > 1) ? $clog2(N_TIERS) : 1;
  localparam int SH_W   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [TIER_W-1:0] LAST_TIER  = TIER_W'(N_TIERS - 1);
  localparam logic [SH_W-1:0]   LAST_SHIFT = SH_W'(CHAIN_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_COL   = '1;

  logic [2:0]                 state;
  logic [1:0]                 mode_q;
  logic [15:0]                pcnt_q;
  logic [15:0]                pat;
  logic [TIER_W-1:0]          tier;
  logic [SH_W-1:0]            sh_cnt;
  logic [N_TIERS-1:0]         tier_oh;
  logic [N_TIERS-1:0]         cmp_vec;
  logic [N_TIERS*MISR_W-1:0]  misr_upd;
  logic                       active;
  logic [15:0]                eop_pat;
  logic [TIER_W-1:0]          eop_tier;
  logic [2:0]                 eop_state;

  // Hybrid alternates per pattern within a tier: even index serial, odd index random-access.
  function automatic logic [2:0] pat_state(input logic [1:0] m, input logic odd);
    logic [2:0] s;
    s = ST_SHIFT;
    if (m == MODE_RAS || (m == MODE_HYB && odd)) s = ST_ACCESS;
    return s;
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                  input logic b);
    logic [MISR_W-1:0] r;
    r = {m[MISR_W-2:0], 1'b0};
    if (m[MISR_W-1]) r = r ^ POLY;
    r[0] = r[0] ^ b;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < N_TIERS; i++) tier_oh[i] = (tier == TIER_W'(i));
  end

  always_comb begin
    misr_upd = misr_sig;
    for (int i = 0; i < N_TIERS; i++) begin
      if (tier_oh[i])
        misr_upd[i*MISR_W +: MISR_W] = misr_next(misr_sig[i*MISR_W +: MISR_W], scan_in);
    end
  end

  always_comb begin
    for (int i = 0; i < N_TIERS; i++)
      cmp_vec[i] = (misr_sig[i*MISR_W +: MISR_W] != golden_sig[i*MISR_W +: MISR_W]);
  end

  // Where the sequencer goes once the current pattern's last strobe completes.
  always_comb begin
    eop_pat   = pat + 16'd1;
    eop_tier  = tier;
    eop_state = pat_state(mode_q, eop_pat[0]);
    if (eop_pat == pcnt_q) begin
      eop_pat = '0;
      if (tier == LAST_TIER) begin
        eop_tier  = '0;
        eop_state = ST_COMPARE;
      end else begin
        eop_tier  = tier + 1'b1;
        eop_state = pat_state(mode_q, 1'b0);
      end
    end
  end

  always_comb begin
    active     = (state == ST_SHIFT) || (state == ST_CAPTURE) || (state == ST_ACCESS);
    shift_en   = (state == ST_SHIFT) && test_enable;
    capture_en = ((state == ST_CAPTURE) || (state == ST_ACCESS)) && test_enable;
    tier_sel   = active ? tier_oh : '0;
    busy       = active || (state == ST_COMPARE);
    done       = (state == ST_DONE);
    state_dbg  = state;
  end

  always_ff @(posedge scan_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_SAS;
      pcnt_q     <= '0;
      pat        <= '0;
      tier       <= '0;
      sh_cnt     <= '0;
      col_addr   <= '0;
      misr_sig   <= '0;
      fault_vec  <= '0;
      fault_flag <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_RSV) begin
              cfg_err <= 1'b1;
            end else begin
              mode_q     <= mode;
              pcnt_q     <= pattern_cnt;
              pat        <= '0;
              tier       <= '0;
              sh_cnt     <= '0;
              col_addr   <= '0;
              misr_sig   <= '0;
              fault_vec  <= '0;
              fault_flag <= 1'b0;
              state      <= (pattern_cnt == 16'd0) ? ST_COMPARE : pat_state(mode, 1'b0);
            end
          end
        end
        ST_SHIFT: begin
          if (test_enable) begin
            misr_sig <= misr_upd;
            if (sh_cnt == LAST_SHIFT) begin
              sh_cnt <= '0;
              state  <= ST_CAPTURE;
            end else begin
              sh_cnt <= sh_cnt + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          if (test_enable) begin
            pat   <= eop_pat;
            tier  <= eop_tier;
            state <= eop_state;
          end
        end
        ST_ACCESS: begin
          if (test_enable) begin
            misr_sig <= misr_upd;
            col_addr <= col_addr + 1'b1;
            if (col_addr == LAST_COL) begin
              pat   <= eop_pat;
              tier  <= eop_tier;
              state <= eop_state;
            end
          end
        end
        ST_COMPARE: begin
          fault_vec  <= cmp_vec;
          fault_flag <= |cmp_vec;
          state      <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jscan_tier_seq.sv
// Bench for jscan_tier_seq: a per-strobe schedule model predicts strobes, addresses,
// tier selects, signatures and verdicts for directed and randomized runs.
module tb_jscan_tier_seq;

  localparam int N  = 3;
  localparam int CL = 8;
  localparam int AW = 4;
  localparam int MW = 16;
  localparam logic [15:0] POLY = 16'h100B;

  logic          scan_clk;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [15:0]   pattern_cnt;
  logic          test_enable;
  logic          scan_in;
  logic [N*MW-1:0] golden_sig;
  logic [N-1:0]  tier_sel;
  logic [AW-1:0] col_addr;
  logic          shift_en;
  logic          capture_en;
  logic [N*MW-1:0] misr_sig;
  logic [N-1:0]  fault_vec;
  logic          fault_flag;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [2:0]    state_dbg;

  jscan_tier_seq #(
    .N_TIERS(N), .CHAIN_LEN(CL), .ADDR_W(AW), .MISR_W(MW), .POLY(POLY)
  ) dut (
    .scan_clk(scan_clk), .reset(reset), .start(start), .mode(mode),
    .pattern_cnt(pattern_cnt), .test_enable(test_enable), .scan_in(scan_in),
    .golden_sig(golden_sig), .tier_sel(tier_sel), .col_addr(col_addr),
    .shift_en(shift_en), .capture_en(capture_en), .misr_sig(misr_sig),
    .fault_vec(fault_vec), .fault_flag(fault_flag), .busy(busy), .done(done),
    .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mm [N];
  int q_tier[$];
  int q_kind[$];   // 0 shift, 1 capture, 2 access
  int q_col[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sig_step(input logic [15:0] m, input logic b);
    int v;
    v = (int'(m) * 2) % 65536;
    if (int'(m) >= 32768) v = v ^ int'(POLY);
    if (b) v = v ^ 1;
    return 16'(v);
  endfunction

  function automatic logic [N*MW-1:0] model_sig();
    logic [N*MW-1:0] s;
    for (int i = 0; i < N; i++) s[i*MW +: MW] = mm[i];
    return s;
  endfunction

  task automatic build_schedule(input logic [1:0] m, input int pc);
    bit ras;
    q_tier.delete(); q_kind.delete(); q_col.delete();
    for (int t = 0; t < N; t++) begin
      for (int p = 0; p < pc; p++) begin
        ras = (m == 2'b01) || (m == 2'b10 && (p % 2) == 1);
        if (!ras) begin
          for (int c = 0; c < CL; c++) begin
            q_tier.push_back(t); q_kind.push_back(0); q_col.push_back(0);
          end
          q_tier.push_back(t); q_kind.push_back(1); q_col.push_back(0);
        end else begin
          for (int c = 0; c < (1 << AW); c++) begin
            q_tier.push_back(t); q_kind.push_back(2); q_col.push_back(c);
          end
        end
      end
    end
  endtask

  // Entered and left one time unit after a rising edge with the DUT idle.
  task automatic run_seq(input logic [1:0] m, input int pc, input int freeze_kind,
                         input int scan_kind, input bit fixed_gold,
                         input logic [N*MW-1:0] gold_val, input logic [N-1:0] flip,
                         input int exp_lat);
    int cyc, steps, freeze_left;
    bit frozen_once;
    logic te_v, si_v;
    logic [N*MW-1:0] g;
    logic [N-1:0] exp_fv;
    build_schedule(m, pc);
    for (int i = 0; i < N; i++) mm[i] = '0;
    cyc = 0; steps = 0; freeze_left = 0; frozen_once = 0;
    mode = m; pattern_cnt = pc[15:0]; start = 1'b1; test_enable = 1'b1; scan_in = 1'b0;
    @(posedge scan_clk); #1 start = 1'b0;
    while (q_kind.size() > 0) begin
      te_v = 1'b1;
      if (freeze_kind == 1) te_v = ($urandom_range(0, 3) != 0);
      else if (freeze_kind == 2) begin
        if (steps == 3 && !frozen_once) begin freeze_left = 4; frozen_once = 1; end
        if (freeze_left > 0) begin te_v = 1'b0; freeze_left--; end
      end
      si_v = (scan_kind == 1) ? (steps == 0) : 1'($urandom_range(0, 1));
      test_enable = te_v; scan_in = si_v;
      @(negedge scan_clk); cyc++;
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      if (te_v) begin
        check("shift_en", shift_en, q_kind[0] == 0);
        check("capture_en", capture_en, q_kind[0] != 0);
        check("col_addr", col_addr, q_col[0]);
        check("tier_sel", tier_sel, 64'(1) << q_tier[0]);
        if (q_kind[0] != 1) mm[q_tier[0]] = sig_step(mm[q_tier[0]], si_v);
        void'(q_tier.pop_front()); void'(q_kind.pop_front()); void'(q_col.pop_front());
        steps++;
      end else begin
        check("frz_shift_en", shift_en, 1'b0);
        check("frz_capture_en", capture_en, 1'b0);
        check("frz_col_addr", col_addr, q_col[0]);
        check("frz_tier_sel", tier_sel, 64'(1) << q_tier[0]);
      end
      @(posedge scan_clk); #1;
    end
    g = fixed_gold ? gold_val : model_sig();
    for (int i = 0; i < N; i++)
      if (flip[i]) g[i*MW +: MW] = g[i*MW +: MW] ^ 16'(1 << $urandom_range(0, 15));
    for (int i = 0; i < N; i++) exp_fv[i] = (mm[i] != g[i*MW +: MW]);
    golden_sig = g;
    test_enable = 1'($urandom_range(0, 1));
    @(negedge scan_clk); cyc++;
    check("busy_cmp", busy, 1'b1);
    check("done_cmp", done, 1'b0);
    check("strobes_cmp", {shift_en, capture_en}, 2'b00);
    @(posedge scan_clk); #1 test_enable = 1'b1;
    @(negedge scan_clk); cyc++;
    check("done", done, 1'b1);
    check("busy_done", busy, 1'b0);
    check("fault_vec", fault_vec, exp_fv);
    check("fault_flag", fault_flag, |exp_fv);
    check("misr_sig", misr_sig, model_sig());
    if (exp_lat > 0) check("latency", cyc, exp_lat);
    @(posedge scan_clk); #1;
    @(negedge scan_clk);
    check("done_clr", done, 1'b0);
    check("state_idle", state_dbg, 3'd0);
    check("fault_hold", fault_vec, exp_fv);
    @(posedge scan_clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; pattern_cnt = '0;
    test_enable = 1'b0; scan_in = 1'b0; golden_sig = '0;
    repeat (2) @(posedge scan_clk);
    @(negedge scan_clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tier_sel", tier_sel, '0);
    check("rst_misr", misr_sig, '0);
    check("rst_fault", {fault_flag, fault_vec, cfg_err}, '0);
    check("rst_state", state_dbg, 3'd0);
    @(posedge scan_clk); #1 reset = 1'b0;

    // SAS, one set bit in the first tier-0 shift
    run_seq(2'b00, 1, 0, 1, 1'b1, {16'h0000, 16'h0000, 16'h0080}, '0, 29);
    check("t0_sig", misr_sig[15:0], 16'h0080);
    check("sas_fault_none", fault_vec, 3'b000);

    run_seq(2'b00, 1, 0, 1, 1'b1, {16'h0001, 16'h0000, 16'h0080}, '0, 29);
    check("sas_fault_t2", fault_vec, 3'b100);
    check("sas_flag_t2", fault_flag, 1'b1);

    run_seq(2'b01, 2, 0, 0, 1'b0, '0, '0, 98);
    run_seq(2'b10, 2, 2, 0, 1'b0, '0, 3'b010, 81);

    // reserved mode is rejected and leaves results untouched
    mode = 2'b11; pattern_cnt = 16'd1; start = 1'b1;
    @(posedge scan_clk); #1 start = 1'b0;
    @(negedge scan_clk);
    check("cfg_err_pulse", cfg_err, 1'b1);
    check("cfg_err_busy", busy, 1'b0);
    check("cfg_err_state", state_dbg, 3'd0);
    check("cfg_err_misr", misr_sig, model_sig());
    @(posedge scan_clk); #1;
    @(negedge scan_clk);
    check("cfg_err_clr", cfg_err, 1'b0);
    check("cfg_err_busy2", busy, 1'b0);
    @(posedge scan_clk); #1;

    run_seq(2'b00, 0, 0, 0, 1'b1, '0, '0, 2);
    check("zero_pat_fault", fault_vec, 3'b000);

    // abort in the middle of a random-access pattern
    mode = 2'b01; pattern_cnt = 16'd1; start = 1'b1; test_enable = 1'b1; scan_in = 1'b1;
    @(posedge scan_clk); #1 start = 1'b0;
    repeat (5) @(posedge scan_clk);
    @(negedge scan_clk);
    check("pre_abort_cap", capture_en, 1'b1);
    check("pre_abort_col", col_addr, 4'd5);
    #1 reset = 1'b1;
    @(posedge scan_clk); #1 reset = 1'b0;
    @(negedge scan_clk);
    check("abort_state", state_dbg, 3'd0);
    check("abort_strobes", {busy, done, shift_en, capture_en, cfg_err}, '0);
    check("abort_addr_tier", {col_addr, tier_sel}, '0);
    check("abort_misr", misr_sig, '0);
    check("abort_fault", {fault_flag, fault_vec}, '0);
    @(posedge scan_clk); #1;
    run_seq(2'b01, 1, 0, 0, 1'b0, '0, 3'b001, 50);

    for (int r = 0; r < 8; r++)
      run_seq(2'($urandom_range(0, 2)), $urandom_range(0, 3), 1, 0, 1'b0, '0,
              3'($urandom_range(0, 7)), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
